// File: rtl/regfile_pkg.sv
// Shared constants and sweep FSM state encoding for the parametrised register file.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_t;
endpackage

// File: rtl/param_regfile_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port, scoreboard, sweep.
interface param_regfile_if import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;
  logic              ctrl_markBusy;
  logic [ADDR_W-1:0] ctrl_busyReg;
  logic              busy_readRegA;
  logic              busy_readRegB;
  logic              ctrl_sweep;
  logic              sweep_active;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB, ctrl_markBusy, ctrl_busyReg, ctrl_sweep,
    input  data_readRegA, data_readRegB, busy_readRegA, busy_readRegB, sweep_active
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB, ctrl_markBusy, ctrl_busyReg, ctrl_sweep,
    output data_readRegA, data_readRegB, busy_readRegA, busy_readRegB, sweep_active
  );
endinterface

// File: rtl/regfile_sweep_fsm.sv
// Sweep engine: walks the clear index from 1 to DEPTH-1, one register per cycle.
module regfile_sweep_fsm import regfile_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sweep_req,
  output logic              o_idle,
  output logic              o_sweep_active,
  output logic              o_clr_stb,
  output logic [ADDR_W-1:0] o_clr_idx
);
  localparam logic [ADDR_W-1:0] LAST_IDX  = '1;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  sweep_state_t      r_state, w_state_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= FIRST_IDX;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Register 0 is hardwired, so the counter never visits index 0.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_sweep_req) begin
          w_state_next = ST_SWEEP;
          w_cnt_next   = FIRST_IDX;
        end
      end
      ST_SWEEP: begin
        if (r_cnt == LAST_IDX) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = FIRST_IDX;
        end else begin
          w_cnt_next = r_cnt + FIRST_IDX;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = FIRST_IDX;
      end
    endcase
  end

  assign o_idle         = (r_state == ST_IDLE);
  assign o_sweep_active = (r_state == ST_SWEEP);
  assign o_clr_stb      = (r_state == ST_SWEEP);
  assign o_clr_idx      = r_cnt;
endmodule

// File: rtl/param_regfile.sv
// Parametrised register file with hardwired r0, optional write bypass, busy scoreboard and sweep clear.
module param_regfile import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input logic            clock,
  input logic            ctrl_reset,
  param_regfile_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic              w_idle;
  logic              w_clr_stb;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_wr_acc;
  logic              w_mk_acc;
  logic              w_fwd_a, w_fwd_b;
  logic [DATA_W-1:0] w_regs [DEPTH];
  logic              w_busy [DEPTH];

  regfile_sweep_fsm #(.ADDR_W(ADDR_W)) u_sweep_fsm (
    .i_clk          (clock),
    .i_rst          (ctrl_reset),
    .i_sweep_req    (bus.ctrl_sweep),
    .o_idle         (w_idle),
    .o_sweep_active (bus.sweep_active),
    .o_clr_stb      (w_clr_stb),
    .o_clr_idx      (w_clr_idx)
  );

  // Gating on reset keeps the bypass path from leaking write data while reset is held.
  assign w_wr_acc = bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0) && w_idle && !ctrl_reset;
  assign w_mk_acc = bus.ctrl_markBusy && (bus.ctrl_busyReg != '0) && w_idle && !ctrl_reset;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_regs[gi] = '0;
        assign w_busy[gi] = 1'b0;
      end else begin : g_store
        logic [DATA_W-1:0] r_data;
        logic              r_busy;
        logic              w_wr_hit, w_mk_hit, w_clr_hit;

        assign w_wr_hit  = w_wr_acc && (bus.ctrl_writeReg == ADDR_W'(gi));
        assign w_mk_hit  = w_mk_acc && (bus.ctrl_busyReg == ADDR_W'(gi));
        assign w_clr_hit = w_clr_stb && (w_clr_idx == ADDR_W'(gi));

        always_ff @(posedge clock or posedge ctrl_reset) begin
          if (ctrl_reset) begin
            r_data <= '0;
            r_busy <= 1'b0;
          end else if (w_clr_hit) begin
            r_data <= '0;
            r_busy <= 1'b0;
          end else begin
            if (w_wr_hit) r_data <= bus.data_writeReg;
            // A new producer issued alongside the retiring write keeps the register busy.
            if (w_mk_hit)      r_busy <= 1'b1;
            else if (w_wr_hit) r_busy <= 1'b0;
          end
        end

        assign w_regs[gi] = r_data;
        assign w_busy[gi] = r_busy;
      end
    end
  endgenerate

  assign w_fwd_a = BYPASS && w_wr_acc && (bus.ctrl_writeReg == bus.ctrl_readRegA);
  assign w_fwd_b = BYPASS && w_wr_acc && (bus.ctrl_writeReg == bus.ctrl_readRegB);

  assign bus.data_readRegA = w_fwd_a ? bus.data_writeReg : w_regs[bus.ctrl_readRegA];
  assign bus.data_readRegB = w_fwd_b ? bus.data_writeReg : w_regs[bus.ctrl_readRegB];

  assign bus.busy_readRegA = (w_fwd_a && !(w_mk_acc && (bus.ctrl_busyReg == bus.ctrl_readRegA)))
                             ? 1'b0 : w_busy[bus.ctrl_readRegA];
  assign bus.busy_readRegB = (w_fwd_b && !(w_mk_acc && (bus.ctrl_busyReg == bus.ctrl_readRegB)))
                             ? 1'b0 : w_busy[bus.ctrl_readRegB];
endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised successor to the processor's 32x32 register file.
- Adds configurable width and depth, a hardwired-zero register 0, optional write-to-read bypass, a per-register busy scoreboard for multicycle producers, and a sequential sweep-clear engine.
- Sits between decode (read ports, busy checks) and writeback (write port) in the pipeline.

Parameters:
- DATA_W, 32, bits per register.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1, 1 = same-cycle write data/busy-clear forwarded to read ports; 0 = reads see stored state only.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- ctrl_writeEnable  in  1  write strobe.
- ctrl_writeReg  in  ADDR_W  write address.
- data_writeReg  in  DATA_W  write data.
- ctrl_readRegA  in  ADDR_W  read address, port A.
- ctrl_readRegB  in  ADDR_W  read address, port B.
- data_readRegA  out  DATA_W  read data, port A (combinational).
- data_readRegB  out  DATA_W  read data, port B (combinational).
- ctrl_markBusy  in  1  set busy bit of ctrl_busyReg.
- ctrl_busyReg  in  ADDR_W  register whose result is pending.
- busy_readRegA  out  1  busy bit of ctrl_readRegA.
- busy_readRegB  out  1  busy bit of ctrl_readRegB.
- ctrl_sweep  in  1  request sequential zeroing of all registers.
- sweep_active  out  1  high while the sweep runs.

Behaviour:
- Reset (async, ctrl_reset=1):
  - All registers = 0; all busy bits = 0; FSM = IDLE; sweep counter = 1.
  - sweep_active = 0; data_readRegA/B = 0; busy_readRegA/B = 0 while reset is held.
- Register 0:
  - Writes ignored; reads return 0; markBusy on it ignored; busy_read for address 0 always 0.
- Write: when ctrl_writeEnable=1, ctrl_writeReg!=0 and FSM=IDLE, register <= data_writeReg at the rising edge. Latency 1.
- Read:
  - Purely combinational from the address.
  - BYPASS=1: if a write is accepted this cycle to the same nonzero address, output data_writeReg.
  - BYPASS=0: output the stored value.
  - Ports A and B are independent; both may address the same register.
- Busy scoreboard, one bit per register:
  - markBusy accepted (FSM=IDLE, reg!=0): bit <= 1 at the edge.
  - Accepted write to a register: its bit <= 0 at the edge.
  - Mark and write to the same register in one cycle: mark wins, bit = 1 (new producer issued).
  - busy_read with BYPASS=1: shows 0 when an accepted write to that address is present this cycle and no mark to it; otherwise shows the stored bit.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE + ctrl_sweep=1: go to SWEEP; counter = 1.
  - Each SWEEP cycle: register[counter] <= 0 and busy[counter] <= 0; counter++.
  - When counter == DEPTH-1 is cleared: return to IDLE next edge.
  - Sweep takes exactly DEPTH-1 cycles; sweep_active = 1 (registered) in every SWEEP cycle.
  - During SWEEP, writes and markBusy are dropped, not queued; ctrl_sweep is ignored.
  - Reads during SWEEP return current stored contents, no bypass.
  - ctrl_sweep in the cycle the FSM returns to IDLE is not acted on; a new sweep needs ctrl_sweep asserted while in IDLE.
- Reset asserted mid-sweep: immediate IDLE, all state cleared.
- Counter is ADDR_W bits and wraps to 1 on re-entry, never to 0.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W constants and the FSM state encoding (IDLE=1'b0, SWEEP=1'b1).
- One sub-module, regfile_sweep_fsm: state, counter, sweep_active, per-cycle clear index and clear strobe.
- Storage, scoreboard and read muxing stay in param_regfile.

Test Plan:
- Reset then read all addresses on both ports -> every data_read = 0 and every busy = 0. Write 0xDEADBEEF to r0 -> r0 still reads 0.
- Write 0x12345678 to r5 and read r5 on port A in the same cycle -> BYPASS=1 shows 0x12345678 that cycle; BYPASS=0 shows 0 that cycle, then 0x12345678 next cycle.
- markBusy r7 -> busy_readRegB(r7) = 1 next cycle. Write r7 -> busy = 0 (same cycle if BYPASS=1). Mark and write r7 together -> busy stays 1 and data updates.
- Load r1..r31 with their index, pulse ctrl_sweep:
  - sweep_active high for exactly 31 cycles; r1 reads 0 after the first cycle, r31 after the 31st.
  - A write to r3 during the sweep is dropped (r3 = 0 afterwards).
- Start a sweep, assert ctrl_reset at sweep cycle 10 -> sweep_active = 0 immediately; all registers 0. After release, a write to r20 works normally.
- DATA_W=64, ADDR_W=3 instance: write r7 = 0xFFFF_FFFF_FFFF_FFFF -> reads back intact; the sweep lasts 7 cycles.
